hdmi_pattern_gen: RTL and testbench
===================================

Name: hdmi_pattern_gen

Overview:
- Video source feeding the HDMI transmitter's r/g/b inputs.
- Consumes the transmitter's row/column outputs and returns pixel colour in the same pix_clk cycle, so the path is zero-latency combinational from row/column.
- Holds per-frame animation state (frame counter, scrolling offset, bouncing box) that updates once per frame at start of vertical blanking.
- Four selectable test patterns are used for bring-up and link checking.

Parameters:
- HACTIVE, 640: active pixels per line; must be divisible by 8.
- VACTIVE, 480: active lines per frame.
- BOX_SIZE, 32: bouncing box edge in pixels; must be < HACTIVE and < VACTIVE.
- BOX_STEP, 2: box displacement per frame per axis; 1 <= BOX_STEP < BOX_SIZE.
- CHECKER_LOG2, 5: log2 of checkerboard square size.

Ports:
- pix_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous active-low reset.
- row  in  16  current line from transmitter counter.
- column  in  16  current pixel from transmitter counter.
- mode  in  2  pattern select, sampled at frame tick only.
- r  out  8  red.
- g  out  8  green.
- b  out  8  blue.
- frame_count  out  16  frames elapsed since reset, wraps 65535->0.
- frame_strobe  out  1  one-cycle pulse, the cycle after each frame tick.

Behaviour:
- Reset values: frame_count=0, frame_strobe=0, mode_q=0, scroll=0, box_x=0, box_y=0, dir_x=+, dir_y=+.
- r/g/b are forced to 0 while reset_n is low. Reset takes effect with no clock edge required.
- frame_tick (internal, combinational) = (row==VACTIVE) && (column==0).
  - Exactly one cycle per frame when driven by the transmitter counter.
  - All state below updates on the pix_clk edge where frame_tick=1.
- On tick:
  - frame_count += 1.
  - mode_q <= mode.
  - scroll <= scroll+1, width CHECKER_LOG2+1 bits, natural wrap.
  - Box axes update.
  - frame_strobe is registered: high the cycle after the tick, low otherwise.
- Box axis update (X: LIMIT=HACTIVE-BOX_SIZE; Y: LIMIT=VACTIVE-BOX_SIZE):
  - dir + and pos+BOX_STEP >= LIMIT: pos=LIMIT, dir becomes -.
  - dir + otherwise: pos += BOX_STEP.
  - dir - and pos <= BOX_STEP: pos=0, dir becomes +.
  - dir - otherwise: pos -= BOX_STEP.
- Blanking: row>=VACTIVE or column>=HACTIVE gives r=g=b=0 in every mode.
- Active pixels by mode_q:
  - 0 colour bars: bar = column/(HACTIVE/8). Colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. Implement with a comparison chain on constant boundaries, no divider.
  - 1 checkerboard: bit0 of (((column+scroll)>>CHECKER_LOG2) ^ (row>>CHECKER_LOG2)). 1 gives FFFFFF, 0 gives 000000. Sum is 16-bit.
  - 2 bouncing box: box_x<=column<box_x+BOX_SIZE and box_y<=row<box_y+BOX_SIZE gives FFFFFF; otherwise background 000080.
  - 3 gradient: r=column[7:0], g=row[7:0], b=frame_count[7:0].
- mode changes mid-frame have no visible effect until the next tick.
- Reset asserted mid-frame clears state immediately. After release, the first tick occurs at the next row==VACTIVE, column==0.
- row/column values outside the transmitter's ranges need no special handling beyond the blanking rule.

Decomposition:
- Shared package hdmi_pkg:
  - pattern_mode_t enum (BARS, CHECKER, BOX, GRADIENT).
  - rgb_t packed struct {r,g,b}.
  - Colour constants (COLOUR_WHITE ... COLOUR_BLACK, COLOUR_BOX_BG).
- One sub-module bounce_axis: params LIMIT, STEP; ports pix_clk, reset_n, tick, pos[15:0], dir. Instantiated twice, once per axis.

Test Plan:
- Colours after reset, mode 0 (reset_n released, row=10):
  - column=0 -> FFFFFF; column=80 -> FFFF00; column=639 -> 000000; column=640 -> 000000.
  - row=480, column=5 -> 000000.
- Frame tick and mode sampling:
  - Free-running 800x525 counter: frame_strobe pulses exactly once per 420000 cycles, one cycle after row=480, column=0.
  - frame_count reads 1 after the first pulse.
  - mode set to 1 at row 100 still yields bars until that tick.
- Box X bounce, mode 2:
  - After 304 ticks box_x=608, dir_x=-.
  - Tick 305 gives box_x=606.
  - Pixel (row=box_y, column=608) -> FFFFFF; column=607 -> 000080.
- Box Y bounce: after 224 ticks box_y=448, dir -; after 448 ticks box_y=0, dir +.
- Checkerboard, mode 1:
  - scroll=0: (row 0, column 0) -> 000000; column 32 -> FFFFFF.
  - After one more tick (scroll=1): column 31 -> FFFFFF.
  - scroll wraps 63->0.
- Asynchronous mid-frame reset:
  - Run to frame_count=5, mode 3.
  - Drop reset_n between clock edges: frame_count=0 and r=g=b=0 with no clock edge.
  - After release, mode_q=0 (bars) until the next tick.

Source files
------------

// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and colour constants for the HDMI pattern source
package hdmi_pkg;

  typedef enum logic [1:0] {
    BARS     = 2'd0,
    CHECKER  = 2'd1,
    BOX      = 2'd2,
    GRADIENT = 2'd3
  } pattern_mode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam rgb_t COLOUR_WHITE   = 24'hFFFFFF;
  localparam rgb_t COLOUR_YELLOW  = 24'hFFFF00;
  localparam rgb_t COLOUR_CYAN    = 24'h00FFFF;
  localparam rgb_t COLOUR_GREEN   = 24'h00FF00;
  localparam rgb_t COLOUR_MAGENTA = 24'hFF00FF;
  localparam rgb_t COLOUR_RED     = 24'hFF0000;
  localparam rgb_t COLOUR_BLUE    = 24'h0000FF;
  localparam rgb_t COLOUR_BLACK   = 24'h000000;
  localparam rgb_t COLOUR_BOX_BG  = 24'h000080;

  // Bar order left to right: the classic SMPTE-style descending-luma sequence.
  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return COLOUR_WHITE;
      3'd1:    return COLOUR_YELLOW;
      3'd2:    return COLOUR_CYAN;
      3'd3:    return COLOUR_GREEN;
      3'd4:    return COLOUR_MAGENTA;
      3'd5:    return COLOUR_RED;
      3'd6:    return COLOUR_BLUE;
      default: return COLOUR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/bounce_axis.sv
// rtl/bounce_axis.sv - one axis of the bouncing box, clamps at 0 and LIMIT
module bounce_axis
  import hdmi_pkg::*;
#(
  parameter int LIMIT = 608,
  parameter int STEP  = 2
) (
  input  logic        pix_clk,
  input  logic        reset_n,
  input  logic        tick,
  output logic [15:0] pos,
  output logic        dir
);

  // One extra bit so the overshoot test cannot wrap near 16'hFFFF.
  logic [16:0] pos_up;

  assign pos_up = {1'b0, pos} + 17'(STEP);

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= 16'd0;
      dir <= DIR_UP;
    end else if (tick) begin
      if (dir == DIR_UP) begin
        if (pos_up >= 17'(LIMIT)) begin
          pos <= 16'(LIMIT);
          dir <= DIR_DOWN;
        end else begin
          pos <= pos_up[15:0];
        end
      end else begin
        if (pos <= 16'(STEP)) begin
          pos <= 16'd0;
          dir <= DIR_UP;
        end else begin
          pos <= pos - 16'(STEP);
        end
      end
    end
  end

endmodule

// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - zero-latency test pattern source with per-frame animation
module hdmi_pattern_gen
  import hdmi_pkg::*;
#(
  parameter int HACTIVE      = 640,
  parameter int VACTIVE      = 480,
  parameter int BOX_SIZE     = 32,
  parameter int BOX_STEP     = 2,
  parameter int CHECKER_LOG2 = 5
) (
  input  logic        pix_clk,
  input  logic        reset_n,
  input  logic [15:0] row,
  input  logic [15:0] column,
  input  logic [1:0]  mode,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic [15:0] frame_count,
  output logic        frame_strobe
);

  localparam int BAR_W = HACTIVE / 8;

  logic                  frame_tick;
  pattern_mode_t         mode_q;
  logic [CHECKER_LOG2:0] scroll;
  logic [15:0]           box_x;
  logic [15:0]           box_y;
  logic                  dir_x;
  logic                  dir_y;

  assign frame_tick = (row == 16'(VACTIVE)) && (column == 16'd0);

  always_ff @(posedge pix_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count  <= 16'd0;
      frame_strobe <= 1'b0;
      mode_q       <= BARS;
      scroll       <= '0;
    end else begin
      frame_strobe <= frame_tick;
      if (frame_tick) begin
        frame_count <= frame_count + 16'd1;
        mode_q      <= pattern_mode_t'(mode);
        scroll      <= scroll + 1'b1;
      end
    end
  end

  bounce_axis #(
    .LIMIT (HACTIVE - BOX_SIZE),
    .STEP  (BOX_STEP)
  ) u_box_x (
    .pix_clk (pix_clk),
    .reset_n (reset_n),
    .tick    (frame_tick),
    .pos     (box_x),
    .dir     (dir_x)
  );

  bounce_axis #(
    .LIMIT (VACTIVE - BOX_SIZE),
    .STEP  (BOX_STEP)
  ) u_box_y (
    .pix_clk (pix_clk),
    .reset_n (reset_n),
    .tick    (frame_tick),
    .pos     (box_y),
    .dir     (dir_y)
  );

  logic        active;
  logic [2:0]  bar_idx;
  logic [15:0] chk_sel;
  logic        checker_on;
  logic        in_box;
  rgb_t        pix;

  assign active = (row < 16'(VACTIVE)) && (column < 16'(HACTIVE));

  // Constant-boundary compare chain keeps the bar index free of a divider.
  always_comb begin
    bar_idx = 3'd7;
    if      (column < 16'(BAR_W * 1)) bar_idx = 3'd0;
    else if (column < 16'(BAR_W * 2)) bar_idx = 3'd1;
    else if (column < 16'(BAR_W * 3)) bar_idx = 3'd2;
    else if (column < 16'(BAR_W * 4)) bar_idx = 3'd3;
    else if (column < 16'(BAR_W * 5)) bar_idx = 3'd4;
    else if (column < 16'(BAR_W * 6)) bar_idx = 3'd5;
    else if (column < 16'(BAR_W * 7)) bar_idx = 3'd6;
  end

  assign chk_sel    = (((column + 16'(scroll)) >> CHECKER_LOG2) ^ (row >> CHECKER_LOG2)) & 16'd1;
  assign checker_on = (chk_sel != 16'd0);

  assign in_box = ({1'b0, column} >= {1'b0, box_x}) &&
                  ({1'b0, column} <  ({1'b0, box_x} + 17'(BOX_SIZE))) &&
                  ({1'b0, row}    >= {1'b0, box_y}) &&
                  ({1'b0, row}    <  ({1'b0, box_y} + 17'(BOX_SIZE)));

  // Reset is folded in combinationally so the link goes black without a clock edge.
  always_comb begin
    pix = COLOUR_BLACK;
    if (reset_n && active) begin
      case (mode_q)
        BARS:     pix = bar_colour(bar_idx);
        CHECKER:  pix = checker_on ? COLOUR_WHITE : COLOUR_BLACK;
        BOX:      pix = in_box ? COLOUR_WHITE : COLOUR_BOX_BG;
        GRADIENT: pix = '{r: column[7:0], g: row[7:0], b: frame_count[7:0]};
        default:  pix = COLOUR_BLACK;
      endcase
    end
  end

  assign r = pix.r;
  assign g = pix.g;
  assign b = pix.b;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// tb/tb_hdmi_pattern_gen.sv - scoreboard bench for hdmi_pattern_gen
`timescale 1ns/1ps
module tb_hdmi_pattern_gen;

  logic        pix_clk = 1'b0;
  logic        reset_n;
  logic [15:0] row;
  logic [15:0] column;
  logic [1:0]  mode;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic [15:0] frame_count;
  logic        frame_strobe;

  always #5 pix_clk = ~pix_clk;

  hdmi_pattern_gen dut (
    .pix_clk      (pix_clk),
    .reset_n      (reset_n),
    .row          (row),
    .column       (column),
    .mode         (mode),
    .r            (r),
    .g            (g),
    .b            (b),
    .frame_count  (frame_count),
    .frame_strobe (frame_strobe)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  logic [23:0] exp_q[$];

  int m_fc, m_mode, m_scroll, m_bx, m_by;
  bit m_dx, m_dy;

  task automatic model_reset();
    m_fc = 0; m_mode = 0; m_scroll = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1;
  endtask

  task automatic axis_step(input int lim, inout int p, inout bit up);
    if (up) begin
      if (p + 2 >= lim) begin p = lim; up = 0; end
      else p = p + 2;
    end else begin
      if (p <= 2) begin p = 0; up = 1; end
      else p = p - 2;
    end
  endtask

  task automatic model_tick();
    m_fc     = (m_fc + 1) % 65536;
    m_mode   = int'(mode);
    m_scroll = (m_scroll + 1) % 64;
    axis_step(608, m_bx, m_dx);
    axis_step(448, m_by, m_dy);
  endtask

  function automatic logic [23:0] model_rgb(input int rr, input int cc);
    if (rr >= 480 || cc >= 640) return 24'h000000;
    case (m_mode)
      0: begin
        case (cc / 80)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return (((((cc + m_scroll) % 65536) / 32) ^ (rr / 32)) % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      2: return (cc >= m_bx && cc < m_bx + 32 && rr >= m_by && rr < m_by + 32) ? 24'hFFFFFF : 24'h000080;
      default: return {8'(cc), 8'(rr), 8'(m_fc)};
    endcase
  endfunction

  task automatic next_cycle();
    @(posedge pix_clk);
    #1;
  endtask

  task automatic drive_px(input int rr, input int cc);
    row = 16'(rr); column = 16'(cc);
    exp_q.push_back(model_rgb(rr, cc));
  endtask

  task automatic drive_px_exp(input int rr, input int cc, input logic [23:0] e);
    row = 16'(rr); column = 16'(cc);
    exp_q.push_back(e);
  endtask

  task automatic do_tick();
    row = 16'd480; column = 16'd0;
    next_cycle();
    model_tick();
    column = 16'd1;
    next_cycle();
  endtask

  task automatic do_reset();
    @(negedge pix_clk); #1;
    reset_n = 1'b0;
    row = 16'd10; column = 16'd0;
    next_cycle();
    @(negedge pix_clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    logic [23:0] got, e;
    reset_n = 1'b0; mode = 2'd0;
    drive_px_exp(10, 0, 24'h000000);
    #2;
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL reset_rgb: got %06h expected %06h", got, e); end
    n_vec++;
    if (frame_count !== 16'd0) begin n_bad++; $display("FAIL reset_frame_count: got %0d expected 0", frame_count); end
    n_vec++;
    if (frame_strobe !== 1'b0) begin n_bad++; $display("FAIL reset_strobe: got %0b expected 0", frame_strobe); end
    next_cycle();
    @(negedge pix_clk); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_bars();
    int          cols [12] = '{0, 79, 80, 160, 240, 320, 400, 480, 560, 639, 640, 5};
    int          rows [12] = '{10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 10, 480};
    logic [23:0] exps [12] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF,
                               24'hFF0000, 24'h0000FF, 24'h000000, 24'h000000, 24'h000000, 24'h000000};
    logic [23:0] got, e;
    for (int i = 0; i < 12; i++) begin
      drive_px_exp(rows[i], cols[i], exps[i]);
      @(negedge pix_clk);
      got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL bars(row %0d col %0d): got %06h expected %06h", rows[i], cols[i], got, e);
      end
    end
  endtask

  task automatic test_frame_window();
    int strobes = 0;
    int hits = 0;
    for (int rr = 476; rr < 484; rr++) begin
      for (int cc = 0; cc < 800; cc++) begin
        row = 16'(rr); column = 16'(cc);
        @(negedge pix_clk);
        if (frame_strobe === 1'b1) begin
          strobes++;
          if (rr == 480 && cc == 1) hits++;
        end
        next_cycle();
        if (rr == 480 && cc == 0) model_tick();
      end
    end
    n_vec++;
    if (strobes != 1) begin n_bad++; $display("FAIL strobe_count: got %0d expected 1", strobes); end
    n_vec++;
    if (hits != 1) begin n_bad++; $display("FAIL strobe_position: got %0d hits at (480,1) expected 1", hits); end
    n_vec++;
    if (frame_count !== 16'd1) begin n_bad++; $display("FAIL frame_count_after_first: got %0d expected 1", frame_count); end
  endtask

  task automatic test_mode_sampling();
    int          rows [5] = '{100, 100, 100, 100, 480};
    int          cols [5] = '{80, 0, 30, 64, 5};
    logic [23:0] got, e;
    row = 16'd100; column = 16'd0; mode = 2'd1;
    drive_px_exp(rows[0], cols[0], 24'hFFFF00);
    @(negedge pix_clk);
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL mode_before_tick: got %06h expected %06h", got, e); end
    do_tick();
    for (int i = 1; i < 5; i++) begin
      drive_px(rows[i], cols[i]);
      @(negedge pix_clk);
      got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL mode_after_tick(row %0d col %0d): got %06h expected %06h", rows[i], cols[i], got, e);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [23:0] got, e;
    mode = 2'd3;
    while (m_fc < 5) do_tick();
    n_vec++;
    if (frame_count !== 16'd5) begin n_bad++; $display("FAIL pre_reset_count: got %0d expected 5", frame_count); end
    drive_px_exp(10, 5, 24'h050A05);
    @(negedge pix_clk);
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL gradient: got %06h expected %06h", got, e); end
    @(posedge pix_clk); #3;
    reset_n = 1'b0;
    exp_q.push_back(24'h000000);
    #1;
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL async_reset_rgb: got %06h expected %06h", got, e); end
    n_vec++;
    if (frame_count !== 16'd0) begin n_bad++; $display("FAIL async_reset_count: got %0d expected 0", frame_count); end
    @(negedge pix_clk); #1;
    reset_n = 1'b1;
    model_reset();
    drive_px_exp(10, 80, 24'hFFFF00);
    @(negedge pix_clk);
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL post_reset_bars: got %06h expected %06h", got, e); end
    do_tick();
    drive_px(10, 5);
    @(negedge pix_clk);
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL post_reset_gradient: got %06h expected %06h", got, e); end
  endtask

  task automatic test_box();
    logic [23:0] got, e;
    int          br;
    do_reset();
    mode = 2'd2;
    for (int t = 1; t <= 448; t++) begin
      do_tick();
      if (t == 224) begin
        n_vec++;
        if (dut.u_box_y.pos !== 16'd448 || dut.u_box_y.dir !== 1'b0) begin
          n_bad++;
          $display("FAIL box_y_top: got pos %0d dir %0b expected 448 dir 0", dut.u_box_y.pos, dut.u_box_y.dir);
        end
      end
      if (t == 304) begin
        n_vec++;
        if (dut.u_box_x.pos !== 16'd608 || dut.u_box_x.dir !== 1'b0) begin
          n_bad++;
          $display("FAIL box_x_right: got pos %0d dir %0b expected 608 dir 0", dut.u_box_x.pos, dut.u_box_x.dir);
        end
        br = m_by;
        drive_px_exp(br, 608, 24'hFFFFFF);
        @(negedge pix_clk);
        got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL box_edge_in: got %06h expected %06h", got, e); end
        drive_px_exp(br, 607, 24'h000080);
        @(negedge pix_clk);
        got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL box_edge_out: got %06h expected %06h", got, e); end
        drive_px(br + 31, 639);
        @(negedge pix_clk);
        got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL box_corner: got %06h expected %06h", got, e); end
        drive_px(br + 32, 620);
        @(negedge pix_clk);
        got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
        if (got !== e) begin n_bad++; $display("FAIL box_below: got %06h expected %06h", got, e); end
      end
      if (t == 305) begin
        n_vec++;
        if (dut.u_box_x.pos !== 16'd606) begin
          n_bad++;
          $display("FAIL box_x_rebound: got pos %0d expected 606", dut.u_box_x.pos);
        end
      end
    end
    n_vec++;
    if (dut.u_box_y.pos !== 16'd0 || dut.u_box_y.dir !== 1'b1) begin
      n_bad++;
      $display("FAIL box_y_bottom: got pos %0d dir %0b expected 0 dir 1", dut.u_box_y.pos, dut.u_box_y.dir);
    end
    drive_px(m_by, m_bx);
    @(negedge pix_clk);
    got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
    if (got !== e) begin n_bad++; $display("FAIL box_final_pixel: got %06h expected %06h", got, e); end
  endtask

  task automatic test_checker();
    int          rows [4] = '{0, 0, 0, 32};
    int          cols [4] = '{0, 32, 31, 31};
    logic [23:0] exps [4] = '{24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'h000000};
    logic [23:0] got, e;
    do_reset();
    mode = 2'd1;
    for (int t = 1; t <= 64; t++) begin
      do_tick();
      if (t == 63 || t == 64) begin
        n_vec++;
        if (int'(dut.scroll) != (t % 64)) begin
          n_bad++;
          $display("FAIL scroll_wrap(t=%0d): got %0d expected %0d", t, dut.scroll, t % 64);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (i == 2) do_tick();
      drive_px_exp(rows[i], cols[i], exps[i]);
      @(negedge pix_clk);
      got = {r, g, b}; e = exp_q.pop_front(); n_vec++;
      if (got !== e) begin
        n_bad++;
        $display("FAIL checker(row %0d col %0d): got %06h expected %06h", rows[i], cols[i], got, e);
      end
    end
  endtask

  initial begin
    row = 16'd10; column = 16'd0; mode = 2'd0; reset_n = 1'b0;
    model_reset();
    test_reset();
    test_bars();
    test_frame_window();
    test_mode_sampling();
    test_async_reset();
    test_box();
    test_checker();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
